dmem_bridge: RTL and testbench

- Sits directly downstream of the pipelined MIPS core's M stage, between the core's data-memory port (aluoutM, writedataM, memwriteM, readdataM) and a variable-latency request/grant/response data bus.
- Turns each single-cycle M-stage load or store into a bus transaction.
- Raises a stall request until the transaction completes, then returns load data to the core.
- Detects misaligned accesses and bus timeouts.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/dmem_timeout_cnt.sv | 30 +++
 rtl/dmem_bridge.sv | 114 +++++++++++
 tb/tb_dmem_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: shared types and defaults for the M-stage data-memory bridge.
// Revision: 1.0
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  // The bus only carries whole words, so the two low address bits must be zero.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
`default_nettype none
// dmem_timeout_cnt: clear/enable cycle counter with a terminal-count flag at TIMEOUT-1.
// Revision: 1.0
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// dmem_bridge: turns M-stage loads/stores into request/grant/response bus transactions,
// stalling the core until completion. Flags misaligned accesses and bus timeouts. Rev 1.0
module dmem_bridge
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  output logic              err_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t state;
  logic   access;
  logic   tmo;

  assign access = memreadM | memwriteM;

  // The IDLE term lets the hazard unit hold the pipeline in the very cycle the access appears.
  assign stallM = ((state == IDLE) && access) || (state == REQ) || (state == RESP);

  dmem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  ((state == REQ) || (state == RESP)),
    .tc  (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      readdataM <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (word_aligned(aluoutM[1:0])) begin
              bus_addr  <= {aluoutM[ADDR_W-1:2], 2'b00};
              bus_wdata <= writedataM;
              bus_we    <= memwriteM;
              bus_req   <= 1'b1;
              state     <= REQ;
              // A simultaneous load and store is served as the store but still flagged.
              if (memreadM && memwriteM) begin
                err_o <= 1'b1;
              end
            end else begin
              readdataM <= '0;
              err_o     <= 1'b1;
              state     <= DONE;
            end
          end
        end

        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= bus_we ? DONE : RESP;
          end else if (tmo) begin
            bus_req   <= 1'b0;
            readdataM <= '0;
            err_o     <= 1'b1;
            state     <= DONE;
          end
        end

        RESP: begin
          if (bus_rvalid) begin
            readdataM <= bus_rdata;
            state     <= DONE;
          end else if (tmo) begin
            readdataM <= '0;
            err_o     <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// tb_dmem_bridge: scoreboard bench with a behavioural bus responder and an M-stage driver.
// Revision: 1.0
module tb_dmem_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, err_o;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  dmem_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .aluoutM   (aluoutM),
    .writedataM(writedataM),
    .readdataM (readdataM),
    .stallM    (stallM),
    .err_o     (err_o),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  int n_checks = 0;
  int n_errs   = 0;
  int txn_cnt  = 0;

  // Responder configuration for the transaction in flight.
  int          cfg_gd = 0;
  int          cfg_rvd = 0;
  logic        cfg_never_gnt = 1'b0;
  logic        cfg_never_rv = 1'b0;
  logic [31:0] cfg_rdata = '0;
  logic        hold = 1'b0;
  logic        spur = 1'b0;

  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus slave: grants after cfg_gd waiting REQ cycles, returns data after cfg_rvd RESP cycles.
  initial begin : responder
    int       ph, w, rw;
    logic     cur_we;
    bus_exp_t e;
    ph = 0; w = 0; rw = 0; cur_we = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (hold || rst) begin
        bus_gnt    = 1'b0;
        bus_rvalid = spur;
        bus_rdata  = 32'hDEADBEEF;
        ph = 0; w = 0;
      end else begin
        case (ph)
          0: begin
            bus_rvalid = 1'b0;
            if (bus_req) begin
              if (bus_q.size() > 0) check("bus_addr_stable", bus_addr, bus_q[0].addr);
              else check("unexpected_req", {31'd0, bus_req}, 32'd0);
              if (!cfg_never_gnt && w == cfg_gd && bus_q.size() > 0) begin
                e = bus_q.pop_front();
                check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                if (e.we) check("bus_wdata", bus_wdata, e.wdata);
                bus_gnt = 1'b1;
                cur_we  = bus_we;
                txn_cnt++;
                ph = 1;
              end else begin
                w++;
              end
            end else begin
              w = 0;
            end
          end
          1, 2: begin
            bus_gnt = 1'b0;
            if (ph == 1) rw = 0;
            if (ph == 1 && cur_we) begin
              ph = 0; w = 0;
            end else if (!cfg_never_rv && rw == cfg_rvd) begin
              bus_rvalid = 1'b1;
              bus_rdata  = cfg_rdata;
              ph = 3;
            end else begin
              rw++;
              ph = 2;
            end
          end
          default: begin
            bus_rvalid = 1'b0;
            ph = 0; w = 0;
          end
        endcase
      end
    end
  end

  // One M-stage access: push expectations, then wait for the DONE cycle and compare.
  task automatic run(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int gd, input logic never_gnt,
                     input int rvd, input logic [31:0] rdata);
    res_exp_t r;
    res_exp_t got;
    bus_exp_t b;
    int       stall_cnt;
    logic     done;
    logic     aligned;
    aligned = (addr[1:0] == 2'b00);
    @(posedge clk); #1;
    memreadM = rd; memwriteM = wr; aluoutM = addr; writedataM = wdata;
    cfg_gd = gd; cfg_never_gnt = never_gnt; cfg_rvd = rvd; cfg_never_rv = 1'b0;
    cfg_rdata = rdata;
    if (!aligned) begin
      m_rd = '0; m_err = 1'b1; r.stall = 1;
    end else begin
      b.we = wr; b.addr = addr; b.wdata = wdata;
      bus_q.push_back(b);
      if (rd && wr) m_err = 1'b1;
      if (never_gnt) begin
        m_rd = '0; m_err = 1'b1; r.stall = 1 + TMO;
      end else if (wr) begin
        r.stall = 2 + gd;
      end else begin
        m_rd = rdata; r.stall = 3 + gd + rvd;
      end
    end
    r.rd = m_rd; r.err = m_err;
    res_q.push_back(r);
    stall_cnt = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (stallM) stall_cnt++;
      else if (stall_cnt > 0) done = 1'b1;
    end
    check("done_reached", {31'd0, done}, 32'd1);
    got = res_q.pop_front();
    check("readdataM", readdataM, got.rd);
    check("err_o", {31'd0, err_o}, {31'd0, got.err});
    check("stall_cycles", stall_cnt, got.stall);
    if (never_gnt && bus_q.size() > 0) begin
      b = bus_q.pop_front();
      check("req_dropped", {31'd0, bus_req}, 32'd0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    memreadM = 1'b0; memwriteM = 1'b0;
  endtask

  initial begin : main
    int t0;
    rst = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_readdataM", readdataM, 32'd0);
    check("rst_err_o", {31'd0, err_o}, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_stallM", {31'd0, stallM}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);

    run(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 0, 1'b0, 0, '0);
    idle_cycle();
    run(1'b1, 1'b0, 32'h200, 32'h0, 2, 1'b0, 1, 32'h12345678);
    idle_cycle();
    run(1'b1, 1'b0, 32'h208, 32'h0, 0, 1'b0, 0, 32'hA5A55A5A);
    idle_cycle();
    run(1'b1, 1'b0, 32'h203, 32'h0, 0, 1'b0, 0, '0);
    idle_cycle();
    run(1'b0, 1'b1, 32'h104, 32'h0BADF00D, 1, 1'b0, 0, '0);
    idle_cycle();
    run(1'b1, 1'b0, 32'h300, 32'h0, 0, 1'b1, 0, '0);
    idle_cycle();
    run(1'b1, 1'b1, 32'h108, 32'h11112222, 0, 1'b0, 0, '0);

    t0 = txn_cnt;
    run(1'b1, 1'b0, 32'h400, 32'h0, 0, 1'b0, 0, 32'h0000BEEF);
    run(1'b1, 1'b0, 32'h404, 32'h0, 1, 1'b0, 0, 32'h7777CAFE);
    idle_cycle();
    check("b2b_txn_count", txn_cnt - t0, 32'd2);

    // Reset while waiting for read data, then a stray rvalid.
    @(posedge clk); #1;
    memreadM = 1'b1; aluoutM = 32'h500;
    cfg_gd = 0; cfg_never_gnt = 1'b0; cfg_never_rv = 1'b1;
    bus_q.push_back('{1'b0, 32'h500, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in_resp_stall", {31'd0, stallM}, 32'd1);
    rst = 1'b1; memreadM = 1'b0; hold = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    check("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("post_rst_readdataM", readdataM, 32'd0);
    check("post_rst_err_o", {31'd0, err_o}, 32'd0);
    check("post_rst_stallM", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    check("spur_ignored_readdataM", readdataM, 32'd0);

    check("bus_q_empty", bus_q.size(), 32'd0);
    check("res_q_empty", res_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
